// File: rtl/picorv32_mem_bridge.sv
// picorv32 native-bus slave: BRAM region, GPIO DATA/SET/CLR block, read wait states, unmapped-access counter.
// Optional synchronised GPIO input readable at GPIO_BASE+0x10 when PICORV32_MEM_BRIDGE_GPIO_IN_EN is defined.
module picorv32_mem_bridge #(
  parameter int          MEM_WORDS  = 256,
  parameter              INIT_FILE  = "",
  parameter int          READ_WAIT  = 0,
  parameter int          GPIO_WIDTH = 8,
  parameter logic [31:0] GPIO_BASE  = 32'h1000_0000,
  parameter logic [31:0] GPIO_RESET = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
`ifdef PICORV32_MEM_BRIDGE_GPIO_IN_EN
  input  logic [GPIO_WIDTH-1:0] gpio_in,
`endif
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [15:0]           err_count
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {R_MEM, R_GPIO, R_GPIN, R_NONE} region_t;

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] mem [MEM_WORDS];

`ifdef PICORV32_MEM_BRIDGE_GPIO_IN_EN
  logic [GPIO_WIDTH-1:0] gpio_meta, gpio_in_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_meta    <= '0;
      gpio_in_sync <= '0;
    end else begin
      gpio_meta    <= gpio_in;
      gpio_in_sync <= gpio_meta;
    end
  end
`endif

  // Acceptance decodes the live bus; a waited read decodes the address latched at acceptance.
  logic [31:0]   addr_sel;
  region_t       region;
  logic [1:0]    offset;
  logic [AW-1:0] word_idx;
  logic          is_write;
  logic [31:0]   rd_data;
  logic [31:0]   lane_mask;
  logic [GPIO_WIDTH-1:0] gpio_wr;

  assign addr_sel = (state == S_IDLE) ? mem_addr : addr_q;
  assign offset   = addr_sel[3:2];
  assign word_idx = addr_sel[AW+1:2];
  assign is_write = |mem_wstrb;
  assign lane_mask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    region = R_NONE;
    if ({2'b00, addr_sel[31:2]} < 32'(MEM_WORDS))
      region = R_MEM;
    else if (addr_sel[31:4] == GPIO_BASE[31:4])
      region = R_GPIO;
`ifdef PICORV32_MEM_BRIDGE_GPIO_IN_EN
    else if (addr_sel[31:4] == GPIO_BASE[31:4] + 28'd1 && addr_sel[3:2] == 2'd0)
      region = R_GPIN;
`endif
  end

  always_comb begin
    rd_data = 32'h0;
    case (region)
      R_MEM:  rd_data = mem[word_idx];
      R_GPIO: rd_data = (offset == 2'd3) ? {16'h0, err_count} : 32'(gpio_out);
`ifdef PICORV32_MEM_BRIDGE_GPIO_IN_EN
      R_GPIN: rd_data = 32'(gpio_in_sync);
`endif
      default: rd_data = 32'h0;
    endcase
  end

  always_comb begin
    gpio_wr = gpio_out;
    case (offset)
      2'd0: gpio_wr = (gpio_out & ~lane_mask[GPIO_WIDTH-1:0])
                    | (mem_wdata[GPIO_WIDTH-1:0] & lane_mask[GPIO_WIDTH-1:0]);
      2'd1: gpio_wr = gpio_out | (mem_wdata[GPIO_WIDTH-1:0] & lane_mask[GPIO_WIDTH-1:0]);
      2'd2: gpio_wr = gpio_out & ~(mem_wdata[GPIO_WIDTH-1:0] & lane_mask[GPIO_WIDTH-1:0]);
      default: gpio_wr = gpio_out;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 3'd0;
      addr_q    <= 32'h0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      gpio_out  <= GPIO_RESET[GPIO_WIDTH-1:0];
      err_count <= 16'h0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_valid) begin
            addr_q <= mem_addr;
            if (region == R_NONE && err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
            if (is_write) begin
              if (region == R_GPIO) begin
                if (offset == 2'd3)
                  err_count <= 16'h0;
                else
                  gpio_out <= gpio_wr;
              end
              state     <= S_RESP;
              mem_ready <= 1'b1;
            end else if (READ_WAIT == 0) begin
              mem_rdata <= rd_data;
              state     <= S_RESP;
              mem_ready <= 1'b1;
            end else begin
              wait_cnt <= 3'(READ_WAIT - 1);
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd0) begin
            mem_rdata <= rd_data;
            state     <= S_RESP;
            mem_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: BRAM contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && state == S_IDLE && mem_valid && region == R_MEM) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Fetches decode exactly like data reads; the byte offset never matters.
  logic unused_ok;
  assign unused_ok = ^{mem_instr, mem_addr[1:0], lane_mask, mem_wdata};

endmodule

// File: tb/tb_picorv32_mem_bridge.sv
// Scoreboard bench for picorv32_mem_bridge: stimulus queues expected responses, a negedge monitor checks them.
module tb_picorv32_mem_bridge;

  localparam int          READ_WAIT  = 3;
  localparam logic [31:0] GPIO_BASE  = 32'h1000_0000;
  localparam logic [7:0]  GPIO_RST   = 8'h81;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  gpio_out;
  logic [15:0] err_count;
`ifdef PICORV32_MEM_BRIDGE_GPIO_IN_EN
  logic [7:0]  gpio_in = 8'h00;
`endif

  picorv32_mem_bridge #(
    .MEM_WORDS (256),
    .INIT_FILE (""),
    .READ_WAIT (READ_WAIT),
    .GPIO_WIDTH(8),
    .GPIO_BASE (GPIO_BASE),
    .GPIO_RESET({24'h0, GPIO_RST})
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
`ifdef PICORV32_MEM_BRIDGE_GPIO_IN_EN
    .gpio_in  (gpio_in),
`endif
    .gpio_out (gpio_out),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Monitor: every ready pulse must match the oldest outstanding transaction.
  always @(negedge clk) begin
    if (!reset && mem_ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        check({e.name, "_rdata"}, mem_rdata, e.rdata);
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp_rd, input string nm, input bit now = 1'b0);
    exp_t e;
    bit   got;
    if (!now) @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    if (s == 4'h0) model_rdata = exp_rd;
    e.rdata = model_rdata;
    e.due   = cyc + 1 + ((s == 4'h0) ? READ_WAIT : 0);
    e.name  = nm;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = mem_ready;
    end
    if (!got) begin
      check({nm, "_timeout"}, 32'(got), 32'h1);
      sb.delete();
    end
    // Valid stays high across the RESP edge; it must not start a second transaction.
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  logic [15:0] exp_err;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_gpio", 32'(gpio_out), 32'(GPIO_RST));
    check("rst_err", 32'(err_count), 32'h0);

    // BRAM byte strobes
    xfer(32'h0, 32'hA5A5_5A5A, 4'b1111, 32'h0, "wr0_full");
    xfer(32'h0, 32'h0000_00FF, 4'b0001, 32'h0, "wr0_byte");
    xfer(32'h0, 32'h0, 4'b0000, 32'hA5A5_5AFF, "rd0");
    xfer(32'h8, 32'h1122_3344, 4'b1111, 32'h0, "wr8_full");
    xfer(32'h8, 32'hAABB_CCDD, 4'b1010, 32'h0, "wr8_mix");
    xfer(32'h8, 32'h0, 4'b0000, 32'hAA22_CC44, "rd8");
    xfer(32'h4, 32'h0BAD_F00D, 4'b1111, 32'h0, "wr4");
    xfer(32'h6, 32'h0, 4'b0000, 32'h0BAD_F00D, "rd4_unaligned");
    xfer(32'h3FC, 32'hCAFE_F00D, 4'b1111, 32'h0, "wr_last");
    xfer(32'h3FD, 32'h0, 4'b0000, 32'hCAFE_F00D, "rd_last");
    xfer(32'h400, 32'hDEAD_BEEF, 4'b1111, 32'h0, "wr_past_end");
    xfer(32'h0, 32'h0, 4'b0000, 32'hA5A5_5AFF, "rd0_after_oob");
    check("err_after_oob", 32'(err_count), 32'h1);

    // GPIO DATA / SET / CLR
    xfer(GPIO_BASE + 32'h0, 32'h0000_00F0, 4'b1111, 32'h0, "gpio_data");
    check("gpio_f0", 32'(gpio_out), 32'hF0);
    xfer(GPIO_BASE + 32'h4, 32'h0000_0003, 4'b1111, 32'h0, "gpio_set");
    check("gpio_f3", 32'(gpio_out), 32'hF3);
    xfer(GPIO_BASE + 32'h8, 32'h0000_0030, 4'b1111, 32'h0, "gpio_clr");
    check("gpio_c3", 32'(gpio_out), 32'hC3);
    xfer(GPIO_BASE + 32'h0, 32'h0, 4'b0000, 32'h0000_00C3, "gpio_rd_data");
    xfer(GPIO_BASE + 32'h8, 32'h0, 4'b0000, 32'h0000_00C3, "gpio_rd_clr");
    xfer(GPIO_BASE + 32'h4, 32'h0000_01FF, 4'b0010, 32'h0, "gpio_set_lane1");
    check("gpio_lane_masked", 32'(gpio_out), 32'hC3);
    xfer(GPIO_BASE + 32'h0, 32'hFFFF_FF00, 4'b1111, 32'h0, "gpio_data_wide");
    check("gpio_00", 32'(gpio_out), 32'h00);

    // Synchronised input window at GPIO_BASE+0x10
`ifdef PICORV32_MEM_BRIDGE_GPIO_IN_EN
    gpio_in = 8'h5A;
    repeat (3) @(negedge clk);
    xfer(GPIO_BASE + 32'h10, 32'h0, 4'b0000, 32'h0000_005A, "gpin_rd");
    exp_err = 16'd1;
`else
    repeat (3) @(negedge clk);
    xfer(GPIO_BASE + 32'h10, 32'h0, 4'b0000, 32'h0, "gpin_unmapped");
    exp_err = 16'd2;
`endif
    xfer(GPIO_BASE + 32'hC, 32'h0, 4'b0000, {16'h0, exp_err}, "errcnt_rd_a");

    // Unmapped counter
    xfer(GPIO_BASE + 32'hC, 32'h0, 4'b0001, 32'h0, "errcnt_clr_a");
    for (int i = 0; i < 3; i++)
      xfer(32'h2000_0000, 32'h0, 4'b0000, 32'h0, "unmapped_rd");
    xfer(GPIO_BASE + 32'hC, 32'h0, 4'b0000, 32'h0000_0003, "errcnt_rd_3");
    xfer(GPIO_BASE + 32'hC, 32'h0, 4'b1000, 32'h0, "errcnt_clr_b");
    xfer(GPIO_BASE + 32'hC, 32'h0, 4'b0000, 32'h0000_0000, "errcnt_rd_0");
    @(negedge clk);
    force dut.err_count = 16'hFFFF;
    @(negedge clk);
    release dut.err_count;
    xfer(32'h2000_0000, 32'h0, 4'b0000, 32'h0, "unmapped_sat");
    xfer(GPIO_BASE + 32'hC, 32'h0, 4'b0000, 32'h0000_FFFF, "errcnt_rd_sat");
    check("err_saturated", 32'(err_count), 32'hFFFF);

    // Reset while a read is waiting
    xfer(GPIO_BASE + 32'h0, 32'h0000_0055, 4'b0001, 32'h0, "gpio_pre_reset");
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h0;
    mem_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(mem_ready), 32'h0);
    check("midrst_rdata", mem_rdata, 32'h0);
    check("midrst_gpio", 32'(gpio_out), 32'(GPIO_RST));
    check("midrst_err", 32'(err_count), 32'h0);
    model_rdata = 32'h0;
    reset = 1'b0;
    xfer(32'h10, 32'h1234_5678, 4'b1111, 32'h0, "post_reset_wr", 1'b1);
    xfer(32'h10, 32'h0, 4'b0000, 32'h1234_5678, "post_reset_rd");
    xfer(32'h0, 32'h0, 4'b0000, 32'hA5A5_5AFF, "bram_kept");

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
